// File: rtl/sprite_pkg.sv
// Shared sprite definitions for the sprite loader and the player-draw blocks.
// Holds the loader FSM state type, the default frame sync marker and the
// per-sprite dimensions so that writer and readers agree on RAM addressing
// (address = y*WIDTH + x).
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO,
        CHK
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int CAT_WIDTH      = 130;
    localparam int CAT_HEIGHT     = 99;
    localparam int CAT_ADDR_WIDTH = 14;

    function automatic int pix_count(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/sprite_loader.sv
// sprite_loader: turns a received byte stream into sprite RAM writes.
//
// Frame: SYNC_BYTE, then one byte pair per pixel ({x,R} then {G,B}), then a
// checksum byte equal to the XOR of every pixel byte (sync excluded).
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active low
//   in_data   received byte
//   in_valid  in_data valid this cycle
//   in_ready  byte accepted (held high once out of reset, never back-pressures)
//   wr_en     RAM write strobe, one cycle per pixel
//   wr_addr   RAM write address (pixel index)
//   wr_data   RGB444 pixel
//   busy      frame in progress
//   done      one-cycle pulse: frame complete, checksum good
//   err       one-cycle pulse: checksum mismatch or inter-byte timeout
module sprite_loader
    import sprite_pkg::*;
#(
    parameter int         SPRITE_WIDTH  = 130,
    parameter int         SPRITE_HEIGHT = 99,
    parameter int         ADDR_WIDTH    = 14,
    parameter int         TIMEOUT       = 1_000_000,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [11:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int PIX = pix_count(SPRITE_WIDTH, SPRITE_HEIGHT);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(PIX - 1);
    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT - 1);

    loader_state_t         state_q;
    logic [ADDR_WIDTH-1:0] pix_q;
    logic [7:0]            csum_q;
    logic [3:0]            r_q;
    logic [TW-1:0]         tmo_q;
    logic                  in_ready_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [11:0]           wr_data_q;
    logic                  done_q;
    logic                  err_q;

    logic accept;
    assign accept = in_valid && in_ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pix_q      <= '0;
            csum_q     <= '0;
            r_q        <= '0;
            tmo_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

            if (accept) begin
                // An accepted byte always restarts the idle timer, even in
                // the cycle the timer would otherwise have expired.
                tmo_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            state_q <= HI;
                            pix_q   <= '0;
                            csum_q  <= '0;
                        end
                    end
                    HI: begin
                        r_q     <= in_data[3:0];
                        csum_q  <= csum_q ^ in_data;
                        state_q <= LO;
                    end
                    LO: begin
                        csum_q    <= csum_q ^ in_data;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= pix_q;
                        wr_data_q <= {r_q, in_data};
                        if (pix_q == LAST_PIX) begin
                            state_q <= CHK;
                        end else begin
                            pix_q   <= pix_q + 1'b1;
                            state_q <= HI;
                        end
                    end
                    CHK: begin
                        if (in_data == csum_q) begin
                            done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                if (tmo_q == TMO_LAST) begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                    tmo_q   <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule
